cache_refill_ctrl: RTL

Line-refill engine for the 4-way, 64-set, 64-byte-line cache: it is the consumer of the LRU victim selection. It accepts a miss, latches the victim way chosen by the replacement logic, and issues a 16-word burst read to memory. Each returned beat is written into the victim way's data RAM, and the requested word is forwarded to the pipeline. On completion it writes the new tag and drives the LRU update (`lru_en` / `lru_visit`).

---
 rtl/cache_refill_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cache_refill_ctrl.sv
// Line-refill engine: accepts a miss, bursts the 64-byte line from memory
// into the victim way, forwards the requested word, then writes the tag and
// touches the LRU for the refilled way.
module cache_refill_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req,
  input  logic [31:0] miss_addr,
  input  logic [3:0]  miss_way_sel,
  output logic        miss_ready,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data,
  output logic [3:0]  data_we,
  output logic [5:0]  data_index,
  output logic [3:0]  data_offset,
  output logic [31:0] data_wdata,
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  output logic [3:0]  tag_we,
  output logic [20:0] tag_wdata,
  output logic        lru_en,
  output logic [3:0]  lru_visit,
  output logic        refill_done,
  output logic        refill_err
);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  // Word address of the miss: bit k holds miss_addr[k+2].
  logic [29:0] addr_reg, addr_next;
  logic [3:0]  way_reg, way_next;

  // Byte-within-word bits never matter for a line refill.
  logic unused_byte_bits;
  assign unused_byte_bits = ^miss_addr[1:0];

  // Fields of the latched miss address.
  assign rd_addr    = {addr_reg[29:4], 6'b0};
  assign data_index = addr_reg[9:4];
  assign tag_wdata  = {1'b1, addr_reg[29:10]};
  assign lru_visit  = way_reg;

  // State, beat counter and miss latches; reset abandons any refill in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 30'd0;
      way_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      way_reg   <= way_next;
    end
  end

  // Next-state and outputs; outputs look idle while reset is held.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    way_next    = way_reg;
    miss_ready  = 1'b0;
    rd_req      = 1'b0;
    data_we     = 4'd0;
    data_offset = cnt_reg;
    data_wdata  = ret_data;
    fwd_valid   = 1'b0;
    fwd_data    = ret_data;
    tag_we      = 4'd0;
    lru_en      = 1'b0;
    refill_done = 1'b0;
    refill_err  = 1'b0;
    if (rst) begin
      miss_ready = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          miss_ready = 1'b1;
          if (miss_req) begin
            addr_next  = miss_addr[31:2];
            way_next   = miss_way_sel;
            cnt_next   = 4'd0;
            state_next = REQ;
          end
        end
        REQ: begin
          rd_req = 1'b1;
          if (rd_rdy) begin
            state_next = RECV;
          end
        end
        RECV: begin
          if (ret_valid) begin
            data_we  = way_reg;
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == addr_reg[3:0]) begin
              fwd_valid = 1'b1;
            end
            // The beat count, not ret_last, decides completion.
            if (ret_last != (cnt_reg == 4'd15)) begin
              refill_err = 1'b1;
            end
            if (cnt_reg == 4'd15) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          tag_we      = way_reg;
          lru_en      = 1'b1;
          refill_done = 1'b1;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
